// File: rtl/seg_adder_pkg.sv
// Shared types and defaults for the segmented ripple-carry adder.
// The seg_adder top imports this package.
package seg_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int SEG_ADDER_N = 8;
    localparam int SEG_ADDER_W = 2;

    // The segment counter needs at least one bit, even when there is only one segment.
    function automatic int segIdxWidth(input int segCount);
        return (segCount > 1) ? $clog2(segCount) : 1;
    endfunction

endpackage

// File: rtl/seg_adder_rca_slice.sv
// Purely combinational W-bit ripple-carry slice built from full-adder bit cells.
module rca_slice #(
    parameter int W = 2
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         ci_i,
    output logic [W-1:0] s_o,
    output logic         co_o
);

    logic [W:0] carry;

    assign carry[0] = ci_i;

    for (genvar i = 0; i < W; i++) begin : gBit
        assign s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign co_o = carry[W];

endmodule

// File: rtl/seg_adder.sv
// Multi-cycle segmented adder: adds N-bit operands W bits per clock, LSB segment first.
// Define SEG_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module seg_adder
    import seg_adder_pkg::*;
#(
    parameter int N = SEG_ADDER_N,
    parameter int W = SEG_ADDER_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout
`ifdef SEG_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int S  = N / W;
    localparam int SW = segIdxWidth(S);
    localparam logic [SW-1:0] LAST_SEG = SW'(S - 1);

    if ((W < 1) || (W > N) || ((N % W) != 0)) begin : gParamCheck
        $error("seg_adder: N must be a positive multiple of W");
    end

    state_e        state_q, state_d;
    logic [SW-1:0] seg_q, seg_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  work_q, work_d;
    logic          carry_q, carry_d;
    logic [N-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          out_valid_q, out_valid_d;
`ifdef SEG_ADDER_OVF_EN
    logic          ovf_q, ovf_d;
`endif

    int            segBase;
    logic [W-1:0]  sliceA;
    logic [W-1:0]  sliceB;
    logic [W-1:0]  sliceS;
    logic          sliceCo;

    always_comb begin
        segBase = int'(seg_q) * W;
        sliceA  = a_q[segBase +: W];
        sliceB  = b_q[segBase +: W];
    end

    rca_slice #(
        .W(W)
    ) u_slice (
        .a_i (sliceA),
        .b_i (sliceB),
        .ci_i(carry_q),
        .s_o (sliceS),
        .co_o(sliceCo)
    );

    always_comb begin
        state_d     = state_q;
        seg_d       = seg_q;
        a_d         = a_q;
        b_d         = b_q;
        work_d      = work_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
`ifdef SEG_ADDER_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    seg_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                work_d[segBase +: W] = sliceS;
                carry_d              = sliceCo;
                // The final segment publishes the freshly completed work word, not the stale register.
                if (seg_q == LAST_SEG) begin
                    sum_d       = work_d;
                    cout_d      = sliceCo;
                    out_valid_d = 1'b1;
`ifdef SEG_ADDER_OVF_EN
                    ovf_d       = (a_q[N-1] == b_q[N-1]) && (work_d[N-1] != a_q[N-1]);
`endif
                    state_d     = DONE;
                end else begin
                    seg_d = seg_q + SW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            seg_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            work_q      <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SEG_ADDER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            seg_q       <= seg_d;
            a_q         <= a_d;
            b_q         <= b_d;
            work_q      <= work_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
`ifdef SEG_ADDER_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef SEG_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_seg_adder.sv
// Self-checking bench for seg_adder: a default N=8/W=2 instance plus an N=8/W=8 instance.
module tb_seg_adder;

    localparam int N = 8;
    localparam int LAT2 = 4;
    localparam int LAT8 = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         inValid, inReady, outValid, outReady, cin, cout;
    logic [N-1:0] a, b, sum;
    logic         inValid8, inReady8, outValid8, outReady8, cin8, cout8;
    logic [N-1:0] a8, b8, sum8;
`ifdef SEG_ADDER_OVF_EN
    logic         ovf, ovf8;
`endif

    int passCount = 0;
    int totalCount = 0;

    always #5 clk = ~clk;

    seg_adder #(.N(8), .W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
        .a(a), .b(b), .cin(cin), .out_valid(outValid), .out_ready(outReady),
        .sum(sum), .cout(cout)
`ifdef SEG_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    seg_adder #(.N(8), .W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(inValid8), .in_ready(inReady8),
        .a(a8), .b(b8), .cin(cin8), .out_valid(outValid8), .out_ready(outReady8),
        .sum(sum8), .cout(cout8)
`ifdef SEG_ADDER_OVF_EN
        , .ovf(ovf8)
`endif
    );

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vc;
        logic [7:0] expSum;
        logic       expCout;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Offer one operand pair, then count edges until out_valid rises (bounded).
    task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                                 output int lat);
        @(negedge clk);
        checkOutput("in_ready before accept", 32'(inReady), 32'd1);
        a = va; b = vb; cin = vc; inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'b0;
        lat = 0;
        while (!outValid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic checkResult(input string tag, input logic [7:0] va, input logic [7:0] vb,
                               input logic vc, input logic [7:0] expSum, input logic expCout,
                               input int lat);
        logic expOvf;
        expOvf = (va[7] == vb[7]) && (expSum[7] != va[7]);
        checkOutput({tag, " latency"}, 32'(lat), 32'(LAT2));
        checkOutput({tag, " sum"}, 32'(sum), 32'(expSum));
        checkOutput({tag, " cout"}, 32'(cout), 32'(expCout));
`ifdef SEG_ADDER_OVF_EN
        checkOutput({tag, " ovf"}, 32'(ovf), 32'(expOvf));
`else
        if (expOvf && vc) ; 
`endif
    endtask

    task automatic releaseResult(input int stall);
        repeat (stall) begin
            @(posedge clk); #1;
            checkOutput("out_valid held in stall", 32'(outValid), 32'd1);
        end
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        checkOutput("out_valid after handshake", 32'(outValid), 32'd0);
        checkOutput("in_ready after handshake", 32'(inReady), 32'd1);
    endtask

    initial begin
        vec_t vecs[8];
        int   lat;
        logic [7:0] ra, rb;
        logic rc;
        logic [8:0] full;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[3] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[6] = '{8'h0F, 8'hF1, 1'b0, 8'h00, 1'b1};
        vecs[7] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};

        rst = 1'b1;
        inValid = 1'b0; outReady = 1'b0; a = '0; b = '0; cin = 1'b0;
        inValid8 = 1'b0; outReady8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        @(posedge clk); #1;
        checkOutput("reset in_ready", 32'(inReady), 32'd1);
        checkOutput("reset out_valid", 32'(outValid), 32'd0);
        checkOutput("reset sum", 32'(sum), 32'd0);
        checkOutput("reset cout", 32'(cout), 32'd0);
`ifdef SEG_ADDER_OVF_EN
        checkOutput("reset ovf", 32'(ovf), 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].va, vecs[i].vb, vecs[i].vc, lat);
            checkResult($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vc,
                        vecs[i].expSum, vecs[i].expCout, lat);
            releaseResult(0);
        end

        // Reset on the second ADD cycle; the previous result 0xFF must hold until then.
        @(negedge clk);
        a = 8'h33; b = 8'h44; cin = 1'b0; inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        checkOutput("sum held in ADD", 32'(sum), 32'hFF);
        checkOutput("in_ready low in ADD", 32'(inReady), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("abort in_ready", 32'(inReady), 32'd1);
        checkOutput("abort out_valid", 32'(outValid), 32'd0);
        checkOutput("abort sum", 32'(sum), 32'd0);
        checkOutput("abort cout", 32'(cout), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("no result after abort", 32'(outValid), 32'd0);
        applyStimulus(8'h01, 8'h01, 1'b0, lat);
        checkResult("post-abort", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, lat);
        releaseResult(0);

        // Hold DONE for 5 cycles while pulsing in_valid with other operands.
        applyStimulus(8'hFF, 8'h01, 1'b0, lat);
        checkResult("stall", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = 8'h12; b = 8'h34; inValid = 1'b1;
            @(posedge clk); #1;
            inValid = 1'b0;
            checkOutput("stall out_valid", 32'(outValid), 32'd1);
            checkOutput("stall sum", 32'(sum), 32'h00);
            checkOutput("stall cout", 32'(cout), 32'd1);
            checkOutput("stall in_ready", 32'(inReady), 32'd0);
        end
        releaseResult(0);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("ignored pulses start nothing", 32'(outValid), 32'd0);

        // Single-segment instance: ADD lasts exactly one cycle.
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1; inValid8 = 1'b1;
        @(posedge clk); #1;
        inValid8 = 1'b0;
        lat = 0;
        while (!outValid8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("w8 latency", 32'(lat), 32'(LAT8));
        checkOutput("w8 sum", 32'(sum8), 32'h01);
        checkOutput("w8 cout", 32'(cout8), 32'd1);
`ifdef SEG_ADDER_OVF_EN
        checkOutput("w8 ovf", 32'(ovf8), 32'd1);
`endif
        outReady8 = 1'b1;
        @(posedge clk); #1;
        outReady8 = 1'b0;
        checkOutput("w8 in_ready after handshake", 32'(inReady8), 32'd1);

        // Random operands with random downstream stalls against a+b+cin.
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            full = 9'(ra) + 9'(rb) + 9'(rc);
            applyStimulus(ra, rb, rc, lat);
            checkResult($sformatf("rand%0d", i), ra, rb, rc, full[7:0], full[8], lat);
            releaseResult($urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
